// File: rtl/sel_pipe_pkg.sv
// Shared definitions for sel_pipe: FIFO occupancy states, default data width
// and the select-width helper.
package sel_pipe_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  function automatic int sel_w(input int n);
    if (n > 2) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sel_pipe_rr_arbiter.sv
// Round-robin search: grants the first requesting channel after i_pointer,
// wrapping from NCH-1 back to 0.
module rr_arbiter #(
  parameter int NCH  = 2,
  parameter int SELW = 1
) (
  input  logic [NCH-1:0]  i_req,
  input  logic [SELW-1:0] i_pointer,
  output logic [SELW-1:0] o_grant,
  output logic            o_grant_valid
);

  logic [2*NCH-1:0] w_dbl;

  // Rotate the doubled request vector so bit 0 is the channel after the
  // pointer; scanning downwards lets the nearest requester win.
  always_comb begin
    w_dbl         = {i_req, i_req} >> (int'(i_pointer) + 1);
    o_grant       = '0;
    o_grant_valid = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      o_grant       = w_dbl[k] ? SELW'((int'(i_pointer) + 1 + k) % NCH) : o_grant;
      o_grant_valid = o_grant_valid | w_dbl[k];
    end
  end

endmodule

// File: rtl/sel_pipe.sv
// Channel selector feeding a 2-entry FIFO. Define SEL_PIPE_RR_EN to add the
// rr_mode port and round-robin arbitration across channels.
module sel_pipe
  import sel_pipe_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = 2,
  localparam int SELW  = sel_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
`ifdef SEL_PIPE_RR_EN
  input  logic                 rr_mode,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  fifo_state_e      r_state;
  fifo_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_head_data;
  logic [WIDTH-1:0] r_tail_data;
  logic [SELW-1:0]  r_head_ch;
  logic [SELW-1:0]  r_tail_ch;
  logic [WIDTH-1:0] w_in_word;
  logic [SELW-1:0]  w_grant;
  logic             w_grant_valid;
  logic             w_fix_valid;
  logic             w_push;
  logic             w_pop;

  assign w_fix_valid = (32'(sel) < 32'(NCH));

`ifdef SEL_PIPE_RR_EN
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_rr_grant;
  logic            w_rr_valid;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .i_req         (in_valid),
    .i_pointer     (r_ptr),
    .o_grant       (w_rr_grant),
    .o_grant_valid (w_rr_valid)
  );

  // Grant source: round-robin search or the explicit select.
  always_comb begin
    w_grant       = sel;
    w_grant_valid = w_fix_valid;
    if (rr_mode) begin
      w_grant       = w_rr_grant;
      w_grant_valid = w_rr_valid;
    end else begin
      w_grant       = sel;
      w_grant_valid = w_fix_valid;
    end
  end

  // Pointer only advances on an accepted round-robin transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SELW'(NCH - 1);
    end else if (rr_mode && w_push) begin
      r_ptr <= w_grant;
    end
  end
`else
  assign w_grant       = sel;
  assign w_grant_valid = w_fix_valid;
`endif

  // Ready is gated by rst_n so it drops the moment reset asserts.
  always_comb begin
    in_ready  = '0;
    w_in_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant == SELW'(i)) begin
        in_ready[i] = w_grant_valid && (r_state != FULL) && rst_n;
        w_in_word   = in_data[i*WIDTH +: WIDTH];
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  assign w_push    = |(in_valid & in_ready);
  assign w_pop     = out_valid && out_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_head_data;
  assign out_ch    = r_head_ch;
  assign count     = r_state;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_push) w_state_nxt = ONE;
        else        w_state_nxt = EMPTY;
      end
      ONE: begin
        if (w_push && !w_pop)      w_state_nxt = FULL;
        else if (!w_push && w_pop) w_state_nxt = EMPTY;
        else                       w_state_nxt = ONE;
      end
      FULL: begin
        if (w_pop) w_state_nxt = ONE;
        else       w_state_nxt = FULL;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Entry storage; vacated slots are zeroed so an empty head reads as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_head_ch   <= '0;
      r_tail_data <= '0;
      r_tail_ch   <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head_data <= w_in_word;
            r_head_ch   <= w_grant;
          end
        end
        ONE: begin
          if (w_push) begin
            if (w_pop) begin
              r_head_data <= w_in_word;
              r_head_ch   <= w_grant;
            end else begin
              r_tail_data <= w_in_word;
              r_tail_ch   <= w_grant;
            end
          end else if (w_pop) begin
            r_head_data <= '0;
            r_head_ch   <= '0;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_ch   <= r_tail_ch;
            r_tail_data <= '0;
            r_tail_ch   <= '0;
          end
        end
        default: begin
          r_head_data <= '0;
          r_head_ch   <= '0;
          r_tail_data <= '0;
          r_tail_ch   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/sel_pipe.md
SEL_PIPE -- requirements
Module: sel_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width of every channel and of the output.
REQ-002 Parameter NCH, default 2, number of input channels (range 2..16); SELW = max(1, clog2(NCH)).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  NCH  per-channel valid.
REQ-007 in_ready  output  NCH  per-channel ready; at most one bit high per cycle.
REQ-008 sel  input  SELW  explicit channel select (fixed mode).
REQ-009 rr_mode  input  1  1 = round-robin arbitration, 0 = fixed select; present only with SEL_PIPE_RR_EN.
REQ-010 out_data  output  WIDTH  head entry data.
REQ-011 out_ch  output  SELW  channel index the head entry came from.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  downstream accepts head.
REQ-014 count  output  2  buffer occupancy, 0..2.

Function
REQ-015 Block SHALL be a selector feeding a 2-entry FIFO; transfer on a channel when in_valid[i] && in_ready[i]; pop when out_valid && out_ready.
REQ-016 Grant g: fixed mode g = sel; sel >= NCH SHALL produce no grant (in_ready all 0).
REQ-017 in_ready[i] SHALL equal (i == g) && (count < 2); no combinational path from out_ready to in_ready.
REQ-018 Latency: word accepted at edge k SHALL appear on out_data/out_ch with out_valid=1 after edge k when buffer was empty.
REQ-019 FIFO order SHALL be preserved; out_valid = (count != 0); out_data/out_ch hold when not popped.
REQ-020 States EMPTY(0), ONE(1), FULL(2): push only -> +1; pop only -> -1; push and pop same cycle -> count unchanged, new word queued behind head; push impossible in FULL.
REQ-021 Pop from EMPTY SHALL not occur (out_valid=0); out_ready ignored.
REQ-022 out_data/out_ch SHALL be 0 when count = 0.
REQ-023 Changing sel while a word is held SHALL not alter stored entries.

Reset
REQ-024 rst_n low SHALL immediately force count=0, out_valid=0, out_data=0, out_ch=0, in_ready=0, round-robin pointer = NCH-1.
REQ-025 Reset mid-transfer SHALL discard both FIFO entries; first accept possible on first edge after rst_n rises.

Configuration
REQ-026 Macro SEL_PIPE_RR_EN defined: rr_mode port exists; rr_mode=1 grants the first channel with in_valid set, searching from pointer+1 with wrap at NCH-1 -> 0; pointer updates to granted channel only on an accepted transfer; sel ignored.
REQ-027 Macro undefined: no rr_mode port, no pointer register; fixed-select behaviour only.

Structure
REQ-028 Shared package sel_pipe_pkg SHALL hold state encodings EMPTY/ONE/FULL and default WIDTH=16.
REQ-029 Round-robin search SHALL live in sub-module rr_arbiter (inputs req, pointer; output grant index, grant_valid), instantiated only under SEL_PIPE_RR_EN.

Verification
REQ-030 NCH=2, sel=1, in_data ch0=28 ch1=2, in_valid=2'b11, out_ready=1 -> after one edge out_data=2, out_ch=1, count=1, in_ready=2'b10.
REQ-031 sel=0, ch0=30 then 7 on consecutive edges, out_ready=0 -> count=2, in_ready=0, out_data=30; raise out_ready -> 30 then 7 popped in order.
REQ-032 count=2, simultaneous pop and push attempt -> push refused (in_ready=0), count=1, next edge push accepted.
REQ-033 NCH=3, sel=3 with in_valid=3'b111 -> in_ready=0 for 10 cycles, count stays 0.
REQ-034 SEL_PIPE_RR_EN, NCH=4, rr_mode=1, in_valid=4'b1111, out_ready=1 -> out_ch sequence 0,1,2,3,0; with in_valid=4'b1010 -> 1,3,1.
REQ-035 count=2, rst_n pulsed low between edges -> outputs zero immediately, out_valid=0 before next edge.
